aes_key_sched_ctrl: RTL and testbench

Sequencer for the AES-128 round-key datapath (aes_key_gen). It accepts a cipher key over a valid/ready handshake and generates the round constant for each round. It drives the datapath one round at a time, capturing each result and replaying it as the next round's input. Round keys 0..10 stream to the cipher core over a valid/ready interface with backpressure; the datapath is never free-run, so consumer stalls are lossless.

---
 rtl/aes_key_sched_ctrl.sv | 134 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
//   Sequencer for the AES-128 round-key datapath (aes_key_gen). A cipher key
//   is accepted over key_valid/key_ready. The controller then drives the
//   datapath one round at a time. Each result is captured into rk_q and fed
//   back as the next round's input. Round keys 0..10 are offered on a
//   valid/ready stream. The datapath only runs between handshakes, so
//   consumer backpressure loses nothing.
//
// Ports
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   key_valid/ready/in   cipher key input handshake (word 0 in [127:96])
//   rk_valid/ready       round key output handshake
//   rk_data/idx/last     round key, round number 0..10, last-round flag
//   dp_key/rcon          datapath key and round constant inputs
//   dp_gen_key           datapath uses the controller rcon (tied 1)
//   dp_next_rnd          datapath always takes dp_key (tied 0)
//   dp_en                datapath enable, high while a round is computed
//   dp_rk                datapath round key result
//   busy                 high whenever the controller is not idle
module aes_key_sched_ctrl #(
   parameter int unsigned ROUND_LAT  = 2,
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key_in,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_data,
   output logic [3:0]   rk_idx,
   output logic         rk_last,
   output logic [127:0] dp_key,
   output logic [9:0]   dp_rcon,
   output logic         dp_gen_key,
   output logic         dp_next_rnd,
   output logic         dp_en,
   input  logic [127:0] dp_rk,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      CALC = 2'd2
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);
   localparam logic [2:0] LAT_END  = 3'(ROUND_LAT - 1);

   state_t       state;
   state_t       state_nxt;
   logic [127:0] rk_q;
   logic [3:0]   idx_q;
   logic [7:0]   rcon_q;
   logic [2:0]   lat_q;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   // next-state and outputs
   always_comb begin
      state_nxt = state;
      key_ready = 1'b0;
      rk_valid  = 1'b0;
      rk_last   = 1'b0;
      dp_en     = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            key_ready = 1'b1;
            busy      = 1'b0;
            if (key_valid) state_nxt = EMIT;
         end
         EMIT: begin
            rk_valid = 1'b1;
            rk_last  = (idx_q == LAST_IDX);
            if (rk_ready) state_nxt = (idx_q == LAST_IDX) ? IDLE : CALC;
         end
         CALC: begin
            dp_en = 1'b1;
            if (lat_q == LAT_END) state_nxt = EMIT;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rk_q   <= '0;
         idx_q  <= '0;
         rcon_q <= 8'h01;
         lat_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (key_valid) begin
                  rk_q   <= key_in;
                  idx_q  <= '0;
                  rcon_q <= 8'h01;
               end
            end
            EMIT: begin
               if (rk_ready && (idx_q != LAST_IDX)) begin
                  idx_q <= idx_q + 4'd1;
                  lat_q <= '0;
                  // round 1 uses the 01 loaded with the key; advance from round 2 on
                  if (idx_q != 4'd0) rcon_q <= xtime(rcon_q);
               end
            end
            CALC: begin
               lat_q <= lat_q + 3'd1;
               if (lat_q == LAT_END) rk_q <= dp_rk;
            end
            default: ;
         endcase
      end
   end

   assign rk_data     = rk_q;
   assign rk_idx      = idx_q;
   assign dp_key      = rk_q;
   assign dp_rcon     = {2'b00, rcon_q};
   assign dp_gen_key  = 1'b1;
   assign dp_next_rnd = 1'b0;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl
//   Directed bench for aes_key_sched_ctrl. Three instances are built, with
//   ROUND_LAT = 2, 1 and 4. Each instance has its own behavioural AES-128
//   key-expansion datapath. The S-box is computed from the GF(2^8) inverse
//   and the affine map. The datapath result is delayed by ROUND_LAT-1
//   registers.
module tb_aes_key_sched_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic         key_valid   [3];
   logic [127:0] key_in      [3];
   logic         rk_ready    [3];
   logic         key_ready   [3];
   logic         rk_valid    [3];
   logic [127:0] rk_data     [3];
   logic [3:0]   rk_idx      [3];
   logic         rk_last     [3];
   logic [127:0] dp_key      [3];
   logic [9:0]   dp_rcon     [3];
   logic         dp_gen_key  [3];
   logic         dp_next_rnd [3];
   logic         dp_en       [3];
   logic [127:0] dp_rk       [3];
   logic         busy        [3];

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY2      = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   logic [7:0]   rc_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
   logic [127:0] exp_rk [0:10];
   logic [127:0] got_rk [0:10];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = '0;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b = '0;
      for (int y = 1; y < 256; y++)
         if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) b = 8'(y);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0 = k[127:96];
      logic [31:0] w1 = k[95:64];
      logic [31:0] w2 = k[63:32];
      logic [31:0] w3 = k[31:0];
      logic [31:0] t;
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rc, 24'h0};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;
      aes_key_sched_ctrl #(.ROUND_LAT(LAT), .NUM_ROUNDS(10)) dut (
         .clk(clk), .rst(rst),
         .key_valid(key_valid[g]), .key_ready(key_ready[g]), .key_in(key_in[g]),
         .rk_valid(rk_valid[g]), .rk_ready(rk_ready[g]), .rk_data(rk_data[g]),
         .rk_idx(rk_idx[g]), .rk_last(rk_last[g]),
         .dp_key(dp_key[g]), .dp_rcon(dp_rcon[g]), .dp_gen_key(dp_gen_key[g]),
         .dp_next_rnd(dp_next_rnd[g]), .dp_en(dp_en[g]), .dp_rk(dp_rk[g]),
         .busy(busy[g])
      );
      logic [127:0] f;
      always_comb f = next_rk(dp_key[g], dp_rcon[g][7:0]);
      if (LAT == 1) begin : g_comb
         assign dp_rk[g] = f;
      end else begin : g_pipe
         logic [127:0] pipe [0:LAT-2];
         always @(posedge clk) begin
            pipe[0] <= f;
            for (int i = 1; i < int'(LAT) - 1; i++) pipe[i] <= pipe[i-1];
         end
         assign dp_rk[g] = pipe[LAT-2];
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
      end
   endtask

   task automatic expand(input logic [127:0] key);
      exp_rk[0] = key;
      for (int r = 1; r <= 10; r++) exp_rk[r] = next_rk(exp_rk[r-1], rc_tab[r-1]);
   endtask

   // Entered at a negedge; that cycle is the key-accept cycle 0. Returns at
   // the negedge of the cycle after the final handshake, with key_valid left
   // high when hold is set.
   task automatic run(input int g, input logic [127:0] key, input int stall_pct,
                      input bit hold, input logic [127:0] key_after);
      int  c    = 0;
      int  ha   = 0;
      int  nexp = 0;
      int  lat  = (g == 0) ? 2 : (g == 1) ? 1 : 4;
      bit  seen = 1'b0;
      expand(key);
      check("idle_key_ready", key_ready[g], 1);
      key_valid[g] = 1'b1;
      key_in[g]    = key;
      rk_ready[g]  = 1'b0;
      while (nexp <= 10) begin
         @(negedge clk);
         c++;
         if (c == 1) begin
            key_valid[g] = hold;
            if (hold) key_in[g] = key_after;
         end
         if (c > 400) begin
            check("timeout_rounds", nexp, 11);
            break;
         end
         check("busy_run", busy[g], 1);
         check("key_ready_busy", key_ready[g], 0);
         check("gen_key", dp_gen_key[g], 1);
         check("next_rnd", dp_next_rnd[g], 0);
         if (rk_valid[g]) begin
            check("dp_en_emit", dp_en[g], 0);
            check("rk_idx", rk_idx[g], nexp);
            check("rk_data", rk_data[g], exp_rk[nexp]);
            check("rk_last", rk_last[g], nexp == 10);
            if (!seen) begin
               check("spacing", c - ha, (nexp == 0) ? 1 : lat + 1);
               got_rk[nexp] = rk_data[g];
               seen = 1'b1;
            end
            rk_ready[g] = ($urandom_range(99) >= stall_pct);
            if (rk_ready[g]) begin
               ha   = c;
               nexp++;
               seen = 1'b0;
            end
         end else if (nexp == 0) begin
            check("round0_valid", rk_valid[g], 1);
         end else begin
            check("dp_en_calc", dp_en[g], 1);
            check("dp_rcon", dp_rcon[g], {2'b00, rc_tab[nexp-1]});
            check("dp_key_calc", dp_key[g], exp_rk[nexp-1]);
            rk_ready[g] = 1'($urandom_range(1));
         end
      end
      @(negedge clk);
      c++;
      rk_ready[g] = 1'b0;
      check("key_ready_ret", key_ready[g], 1);
      check("busy_ret", busy[g], 0);
      check("rk_valid_ret", rk_valid[g], 0);
      if (stall_pct == 0) check("ret_cycle", c, 2 + 10 * (lat + 1));
   endtask

   initial begin
      int  w;
      bit  found;
      rst = 1'b1;
      for (int g = 0; g < 3; g++) begin
         key_valid[g] = 1'b0;
         key_in[g]    = '0;
         rk_ready[g]  = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      check("rst_key_ready", key_ready[0], 1);
      check("rst_rk_valid", rk_valid[0], 0);
      check("rst_rk_last", rk_last[0], 0);
      check("rst_busy", busy[0], 0);
      check("rst_dp_en", dp_en[0], 0);
      check("rst_dp_key", dp_key[0], 0);
      check("rst_dp_rcon", dp_rcon[0], 10'h001);
      check("rst_gen_key", dp_gen_key[0], 1);
      check("rst_next_rnd", dp_next_rnd[0], 0);
      rst = 1'b0;
      @(negedge clk);

      // FIPS-197 key, consumer always ready
      run(0, FIPS_KEY, 0, 1'b0, '0);
      check("fips_rk1", got_rk[1], FIPS_RK1);
      check("fips_rk10", got_rk[10], FIPS_RK10);
      @(negedge clk);

      // same key with random consumer stalls
      run(0, FIPS_KEY, 30, 1'b0, '0);

      // key_valid held high: second key only after the final handshake
      run(0, FIPS_KEY, 0, 1'b1, KEY2);
      run(0, KEY2, 0, 1'b0, '0);
      check("key2_rk10", got_rk[10], KEY2_RK10);

      // reset during round 5 computation
      key_valid[0] = 1'b1;
      key_in[0]    = FIPS_KEY;
      @(negedge clk);
      key_valid[0] = 1'b0;
      rk_ready[0]  = 1'b1;
      found = 1'b0;
      w = 0;
      while (!found && w < 60) begin
         @(negedge clk);
         w++;
         found = (dp_en[0] === 1'b1) && (dp_rcon[0] === 10'h010);
      end
      check("reach_round5_calc", found, 1);
      rst = 1'b1;
      #1;
      check("abort_busy", busy[0], 0);
      check("abort_rk_valid", rk_valid[0], 0);
      check("abort_key_ready", key_ready[0], 1);
      check("abort_dp_rcon", dp_rcon[0], 10'h001);
      check("abort_dp_en", dp_en[0], 0);
      @(negedge clk);
      rst = 1'b0;
      rk_ready[0] = 1'b0;
      @(negedge clk);
      check("post_rst_rk_valid", rk_valid[0], 0);
      check("post_rst_busy", busy[0], 0);
      run(0, FIPS_KEY, 20, 1'b0, '0);

      // other datapath latencies
      run(1, FIPS_KEY, 0, 1'b0, '0);
      run(1, KEY2, 30, 1'b0, '0);
      run(2, FIPS_KEY, 0, 1'b0, '0);
      check("lat4_rk10", got_rk[10], FIPS_RK10);
      run(2, KEY2, 30, 1'b0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
